// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the execute stage: instruction codes, ALU
// function codes, condition codes, status codes, the "no register" ID and the
// packed layouts of the CC and M pipeline registers.
package y86_pkg;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alufn_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } mreg_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  localparam mreg_t M_BUBBLE = '{
    status: STAT_AOK,
    icode:  I_NOP,
    cnd:    1'b0,
    vale:   64'd0,
    vala:   64'd0,
    dste:   RNONE,
    dstm:   RNONE
  };

endpackage

// File: rtl/execute_stage_if.sv
// E-register to M-register pipeline bus of the execute stage.
//   master : drives the E-register fields, observes the M-register fields
//   slave  : the execute stage (consumes E fields, drives M fields)
interface execute_stage_if;
  logic [1:0]  E_status;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_vala;
  logic [63:0] E_valb;
  logic [63:0] E_valc;
  logic [3:0]  E_dste;
  logic [3:0]  E_dstm;

  logic [1:0]  M_status;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_vale;
  logic [63:0] M_vala;
  logic [3:0]  M_dste;
  logic [3:0]  M_dstm;

  modport master (
    output E_status, E_icode, E_ifun, E_vala, E_valb, E_valc, E_dste, E_dstm,
    input  M_status, M_icode, M_cnd, M_vale, M_vala, M_dste, M_dstm
  );

  modport slave (
    input  E_status, E_icode, E_ifun, E_vala, E_valb, E_valc, E_dste, E_dstm,
    output M_status, M_icode, M_cnd, M_vale, M_vala, M_dste, M_dstm
  );
endinterface

// File: rtl/alu64.sv
// 64-bit combinational ALU with Y86 flag generation.
//   alu_a_i, alu_b_i : operands (sub computes b - a)
//   alu_fun_i        : 0 add, 1 sub, 2 and, 3 xor, others give 0
//   result_o         : result modulo 2^64
//   zf_o, sf_o, of_o : zero, sign and signed-overflow flags of result_o
module alu64
  import y86_pkg::*;
(
  input  logic [63:0] alu_a_i,
  input  logic [63:0] alu_b_i,
  input  logic [3:0]  alu_fun_i,
  output logic [63:0] result_o,
  output logic        zf_o,
  output logic        sf_o,
  output logic        of_o
);

  always_comb begin
    result_o = '0;
    of_o     = 1'b0;
    case (alu_fun_i)
      ALU_ADD: begin
        result_o = alu_b_i + alu_a_i;
        of_o     = (alu_a_i[63] == alu_b_i[63]) && (result_o[63] != alu_a_i[63]);
      end
      ALU_SUB: begin
        result_o = alu_b_i - alu_a_i;
        of_o     = (alu_a_i[63] != alu_b_i[63]) && (result_o[63] != alu_b_i[63]);
      end
      ALU_AND: result_o = alu_b_i & alu_a_i;
      ALU_XOR: result_o = alu_b_i ^ alu_a_i;
      default: result_o = '0;
    endcase
  end

  assign zf_o = (result_o == '0);
  assign sf_o = result_o[63];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 pipeline execute stage: ALU operand selection, condition-code
// register, branch/cmov condition evaluation and the M pipeline register.
//   clock, reset_n      : rising-edge clock, async active-low reset
//   ex (slave)          : E-register fields in, M-register fields out
//   m_status, W_status  : downstream status, suppresses CC writes on exceptions
//   M_bubble            : load a bubble into M on the next edge
//   e_vale, e_dste      : combinational forwarding values
//   e_cnd               : condition outcome from the current (pre-update) CC
//   cc_zf, cc_sf, cc_of : condition-code register
module execute_stage
  import y86_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  execute_stage_if.slave ex,
  input  logic [1:0]  m_status,
  input  logic [1:0]  W_status,
  input  logic        M_bubble,
  output logic [63:0] e_vale,
  output logic [3:0]  e_dste,
  output logic        e_cnd,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_fun;
  logic        new_zf, new_sf, new_of;
  logic        set_cc;
  cc_t         cc_q, cc_d;
  mreg_t       m_q, m_d;

  always_comb begin
    alu_a = '0;
    case (ex.E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = ex.E_vala;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex.E_valc;
      I_CALL, I_PUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               alu_a = 64'd8;
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (ex.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = ex.E_valb;
      default: alu_b = '0;
    endcase
  end

  always_comb begin
    alu_fun = ALU_ADD;
    if (ex.E_icode == I_OPQ) alu_fun = ex.E_ifun;
  end

  alu64 u_alu (
    .alu_a_i   (alu_a),
    .alu_b_i   (alu_b),
    .alu_fun_i (alu_fun),
    .result_o  (e_vale),
    .zf_o      (new_zf),
    .sf_o      (new_sf),
    .of_o      (new_of)
  );

  // Status is 2 bits, so "not HLT/ADR/INS" is exactly "AOK". icode==OPQ
  // already excludes the bubble (NOP) case.
  assign set_cc = (ex.E_icode == I_OPQ) && (m_status == STAT_AOK) &&
                  (W_status == STAT_AOK);

  always_comb begin
    cc_d = cc_q;
    if (set_cc) cc_d = '{zf: new_zf, sf: new_sf, of: new_of};
  end

  always_comb begin
    e_cnd = 1'b0;
    case (ex.E_ifun)
      C_YES: e_cnd = 1'b1;
      C_LE:  e_cnd = (cc_q.sf ^ cc_q.of) | cc_q.zf;
      C_L:   e_cnd = cc_q.sf ^ cc_q.of;
      C_E:   e_cnd = cc_q.zf;
      C_NE:  e_cnd = ~cc_q.zf;
      C_GE:  e_cnd = ~(cc_q.sf ^ cc_q.of);
      C_G:   e_cnd = ~(cc_q.sf ^ cc_q.of) & ~cc_q.zf;
      default: e_cnd = 1'b0;
    endcase
  end

  // A not-taken conditional move must not write its destination.
  assign e_dste = ((ex.E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : ex.E_dste;

  always_comb begin
    m_d = M_BUBBLE;
    if (!M_bubble) begin
      m_d = '{
        status: ex.E_status,
        icode:  ex.E_icode,
        cnd:    e_cnd,
        vale:   e_vale,
        vala:   ex.E_vala,
        dste:   e_dste,
        dstm:   ex.E_dstm
      };
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cc_q <= CC_RESET;
      m_q  <= M_BUBBLE;
    end else begin
      cc_q <= cc_d;
      m_q  <= m_d;
    end
  end

  assign cc_zf = cc_q.zf;
  assign cc_sf = cc_q.sf;
  assign cc_of = cc_q.of;

  assign ex.M_status = m_q.status;
  assign ex.M_icode  = m_q.icode;
  assign ex.M_cnd    = m_q.cnd;
  assign ex.M_vale   = m_q.vale;
  assign ex.M_vala   = m_q.vala;
  assign ex.M_dste   = m_q.dste;
  assign ex.M_dstm   = m_q.dstm;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 No parameters; data width is fixed at 64 bits and register IDs at 4 bits.
REQ-002 clock  input  1  rising-edge clock for the CC register and the M register.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 E_status  input  2  status from the E register: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-005 E_icode, E_ifun  input  4 each  instruction code and function from the E register.
REQ-006 E_vala, E_valb, E_valc  input  64 each  operands from the E register.
REQ-007 E_dste, E_dstm  input  4 each  destination register IDs; 4'hF means none.
REQ-008 m_status, W_status  input  2 each  memory-stage and writeback-stage status, used for CC suppression.
REQ-009 M_bubble  input  1  when high, the M register loads a bubble on the next edge.
REQ-010 e_vale  output  64  combinational ALU result, used for forwarding.
REQ-011 e_dste  output  4  combinational effective destination E, used for forwarding.
REQ-012 e_cnd  output  1  combinational condition outcome.
REQ-013 M_status (2), M_icode (4), M_cnd (1), M_vale (64), M_vala (64), M_dste (4), M_dstm (4)  output  registered M-stage values.
REQ-014 cc_zf, cc_sf, cc_of  output  1 each  current condition-code flags.

Function
REQ-015 aluA SHALL be: E_vala for icode 2 or 6; E_valc for icode 3, 4 or 5; -8 for icode 8 or A; +8 for icode 9 or B; 0 otherwise.
REQ-016 aluB SHALL be: E_valb for icode 4, 5, 6, 8, 9, A or B; 0 for icode 2 or 3 and otherwise.
REQ-017 The ALU function SHALL be E_ifun when icode is 6, and add otherwise.
REQ-018 ALU functions SHALL be: 0 = aluB+aluA, 1 = aluB-aluA, 2 = and, 3 = xor, all modulo 2^64; an ifun above 3 with icode 6 SHALL produce 0.
REQ-019 The new flags SHALL be: ZF = (result==0); SF = result[63].
REQ-020 OF for add SHALL be set when the operand signs are equal and the result sign differs from them.
REQ-021 OF for sub SHALL be set when aluA and aluB signs differ and the result sign differs from aluB's sign.
REQ-022 OF for and and xor SHALL be 0.
REQ-023 The CC register SHALL update on the clock edge only when icode==6, neither m_status nor W_status is 2 or 3 or 1, and the E stage is not a bubble (icode!=1).
REQ-024 e_cnd SHALL be a function of ifun and the CURRENT CC (the pre-update flags): 0 true, 1 (SF^OF)|ZF, 2 SF^OF, 3 ZF, 4 !ZF, 5 !(SF^OF), 6 !(SF^OF)&!ZF, other values false.
REQ-025 e_dste SHALL be 4'hF when icode==2 and e_cnd==0; otherwise e_dste SHALL equal E_dste.
REQ-026 M register, when M_bubble==0: SHALL load E_status, E_icode, e_cnd, e_vale, E_vala, e_dste and E_dstm on the rising edge (1-cycle latency).
REQ-027 M register, when M_bubble==1: SHALL load M_status=0, M_icode=1, M_cnd=0, M_vale=0, M_vala=0, M_dste=4'hF, M_dstm=4'hF.
REQ-028 When CC is being written and M_bubble is high in the same cycle, both actions SHALL take effect independently.

Reset
REQ-029 While reset_n is low, the M register SHALL asynchronously hold the bubble values of REQ-027.
REQ-030 While reset_n is low, CC SHALL hold ZF=1, SF=0, OF=0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight instruction, with no partial CC update.

Structure
REQ-032 Icode constants, ALU function codes, status codes and RNONE=4'hF SHALL live in the shared package y86_pkg.
REQ-033 The ALU plus flag generation SHALL be a combinational sub-module named alu64; CC, condition logic and the M register stay in execute_stage.

Verification
REQ-034 Directed test: OPq sub, vala=5, valb=5 -> e_vale=0; next edge ZF=1, SF=0, OF=0.
REQ-035 Directed test: OPq add, vala=valb=64'h7FFF_FFFF_FFFF_FFFF -> e_vale=64'hFFFF_FFFF_FFFF_FFFE, with SF=1, OF=1 after the edge.
REQ-036 Directed test: cmovle (icode 2, ifun 1) with ZF=0, SF=0, OF=0, E_dste=3 -> e_cnd=0 and e_dste=4'hF.
REQ-037 Directed test: OPq with m_status=2 -> CC unchanged across the edge; pushq with valb=64'h100 -> M_vale=64'hF8.
REQ-038 Directed test: M_bubble=1 while E holds mrmovq -> M_icode=1, M_dste=M_dstm=4'hF, M_status=0.
REQ-039 Directed test: reset_n pulsed low mid-clock -> M outputs go to bubble values and CC to Z=1,S=0,O=0 immediately, without waiting for a clock edge.
